// File: rtl/apb_master_bridge_pkg.sv
// apb_master_bridge shared types and sizing constants.
// Optional ACCESS timeout is enabled with APB_TIMEOUT_EN.
package apb_pkg;

  localparam int WIDTH          = 8;
  localparam int MEM_DEPTH      = 16;
  localparam int ADDR_WIDTH     = $clog2(MEM_DEPTH);
  localparam int TIMEOUT_CYCLES = 16;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } apb_mst_state_e;

  typedef struct packed {
    logic                  write;
    logic [ADDR_WIDTH-1:0] addr;
    logic [WIDTH-1:0]      wdata;
  } apb_cmd_t;

endpackage

// File: rtl/apb_master_bridge_if.sv
// Command/response and APB pin bundle of apb_master_bridge.
// Suffixes are relative to the bridge (master modport).
interface apb_master_bridge_if;
  import apb_pkg::*;

  logic                  cmd_valid_i;
  logic                  cmd_ready_o;
  logic                  cmd_write_i;
  logic [ADDR_WIDTH-1:0] cmd_addr_i;
  logic [WIDTH-1:0]      cmd_wdata_i;
  logic                  rsp_valid_o;
  logic                  rsp_ready_i;
  logic [WIDTH-1:0]      rsp_rdata_o;
  logic                  rsp_err_o;
  logic                  psel_o;
  logic                  penable_o;
  logic                  pwrite_o;
  logic [ADDR_WIDTH-1:0] paddr_o;
  logic [WIDTH-1:0]      pwdata_o;
  logic [WIDTH-1:0]      prdata_i;
  logic                  pready_i;
  logic                  pslverr_i;

  modport master (
    input  cmd_valid_i, cmd_write_i,
    input  cmd_addr_i, cmd_wdata_i,
    input  rsp_ready_i,
    input  prdata_i, pready_i, pslverr_i,
    output cmd_ready_o,
    output rsp_valid_o, rsp_rdata_o,
    output rsp_err_o,
    output psel_o, penable_o, pwrite_o,
    output paddr_o, pwdata_o
  );

  modport slave (
    output cmd_valid_i, cmd_write_i,
    output cmd_addr_i, cmd_wdata_i,
    output rsp_ready_i,
    output prdata_i, pready_i, pslverr_i,
    input  cmd_ready_o,
    input  rsp_valid_o, rsp_rdata_o,
    input  rsp_err_o,
    input  psel_o, penable_o, pwrite_o,
    input  paddr_o, pwdata_o
  );

endinterface

// File: rtl/apb_master_bridge_wait_counter.sv
// Saturating wait counter with clear, enable and terminal count.
// Only instantiated when APB_TIMEOUT_EN is defined.
module apb_wait_counter #(
  parameter int MAX = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int W = $clog2(MAX + 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && cnt_q != W'(MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // high on the enabled cycle whose edge makes the count reach MAX
  assign tc_o = en_i && !clr_i && (cnt_q == W'(MAX - 1));

endmodule

// File: rtl/apb_master_bridge.sv
// Single-outstanding APB master: cmd port -> SETUP/ACCESS -> rsp port.
// Define APB_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES waits.
module apb_master_bridge
  import apb_pkg::*;
(
  input  logic                pclk_i,
  input  logic                presetn_i,
  apb_master_bridge_if.master bus
);

  apb_mst_state_e   state_q, state_d;
  apb_cmd_t         cmd_q, cmd_d;
  logic             psel_q, psel_d;
  logic             penable_q, penable_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             err_q, err_d;
  logic             abort;

`ifdef APB_TIMEOUT_EN
  apb_wait_counter #(
    .MAX (TIMEOUT_CYCLES)
  ) u_wait (
    .clk_i  (pclk_i),
    .rst_ni (presetn_i),
    .clr_i  (state_q != ACCESS),
    .en_i   (!bus.pready_i),
    .tc_o   (abort)
  );
`else
  assign abort = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid_i) begin
          cmd_d.write = bus.cmd_write_i;
          cmd_d.addr  = bus.cmd_addr_i;
          cmd_d.wdata = bus.cmd_wdata_i;
          state_d     = SETUP;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (bus.pready_i) begin
          err_d   = bus.pslverr_i;
          rdata_d = cmd_q.write ? '0 : bus.prdata_i;
          state_d = RESP;
        end else if (abort) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // APB strobes are flops driven from the next state
    psel_d    = (state_d == SETUP) || (state_d == ACCESS);
    penable_d = (state_d == ACCESS);
  end

  always_ff @(posedge pclk_i or negedge presetn_i) begin
    if (!presetn_i) begin
      state_q   <= IDLE;
      cmd_q     <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  assign bus.cmd_ready_o = presetn_i && (state_q == IDLE);
  assign bus.rsp_valid_o = (state_q == RESP);
  assign bus.rsp_rdata_o = rdata_q;
  assign bus.rsp_err_o   = err_q;
  assign bus.psel_o      = psel_q;
  assign bus.penable_o   = penable_q;
  assign bus.pwrite_o    = cmd_q.write;
  assign bus.paddr_o     = cmd_q.addr;
  assign bus.pwdata_o    = cmd_q.wdata;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge with a 16x8 APB slave model.
module tb_apb_master_bridge;
  import apb_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  apb_master_bridge_if bus ();

  apb_master_bridge dut (
    .pclk_i    (clk),
    .presetn_i (rst_n),
    .bus       (bus)
  );

  logic [WIDTH-1:0] mem [MEM_DEPTH];
  int  waits;
  int  acc_cnt;
  bit  stuck;
  bit  err_flag;

  assign bus.prdata_i  = mem[bus.paddr_o];
  assign bus.pready_i  = !stuck && (acc_cnt >= waits);
  assign bus.pslverr_i = err_flag;

  always @(posedge clk) begin
    if (bus.psel_o && bus.penable_o && !bus.pready_i)
      acc_cnt <= acc_cnt + 1;
    else
      acc_cnt <= 0;
    if (bus.psel_o && bus.penable_o && bus.pready_i && bus.pwrite_o)
      mem[bus.paddr_o] <= bus.pwdata_o;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // issue one command; return at the first RESP cycle
  task automatic xfer(input bit w, input logic [3:0] a,
                      input logic [7:0] d,
                      output logic [7:0] rd, output logic e,
                      output int lat, output int acc,
                      output bit stable);
    bit done;
    bus.cmd_valid_i = 1'b1;
    bus.cmd_write_i = w;
    bus.cmd_addr_i  = a;
    bus.cmd_wdata_i = d;
    step();
    bus.cmd_valid_i = 1'b0;
    lat = 0; acc = 0; stable = 1; done = 0;
    rd = '0; e = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      lat++;
      if (bus.penable_o) acc++;
      if (bus.psel_o && (bus.paddr_o !== a || bus.pwdata_o !== d))
        stable = 0;
      if (bus.rsp_valid_o) begin
        done = 1;
        rd = bus.rsp_rdata_o;
        e  = bus.rsp_err_o;
      end else begin
        step();
      end
    end
    if (!done) chk("rsp_timeout", 0, 1);
  endtask

  logic [7:0] rd;
  logic       e;
  int         lat, acc;
  bit         stable;

  initial begin
    for (int i = 0; i < MEM_DEPTH; i++) mem[i] = '0;
    waits = 0; acc_cnt = 0; stuck = 0; err_flag = 0;
    bus.cmd_valid_i = 0; bus.cmd_write_i = 0;
    bus.cmd_addr_i = '0; bus.cmd_wdata_i = '0;
    bus.rsp_ready_i = 1;
    rst_n = 0;
    #12;
    chk("rst_psel", bus.psel_o, 0);
    chk("rst_pen", bus.penable_o, 0);
    chk("rst_rspv", bus.rsp_valid_o, 0);
    chk("rst_cmdrdy", bus.cmd_ready_o, 0);
    chk("rst_paddr", bus.paddr_o, 0);
    rst_n = 1;
    step();
    chk("rel_cmdrdy", bus.cmd_ready_o, 1);

    // write 3 <= A5, cycle by cycle
    bus.cmd_valid_i = 1; bus.cmd_write_i = 1;
    bus.cmd_addr_i = 4'h3; bus.cmd_wdata_i = 8'hA5;
    step();
    bus.cmd_valid_i = 0;
    chk("c1_psel", bus.psel_o, 1);
    chk("c1_pen", bus.penable_o, 0);
    chk("c1_paddr", bus.paddr_o, 3);
    chk("c1_pwdata", bus.pwdata_o, 8'hA5);
    chk("c1_pwrite", bus.pwrite_o, 1);
    chk("c1_cmdrdy", bus.cmd_ready_o, 0);
    step();
    chk("c2_psel", bus.psel_o, 1);
    chk("c2_pen", bus.penable_o, 1);
    step();
    chk("c3_rspv", bus.rsp_valid_o, 1);
    chk("c3_err", bus.rsp_err_o, 0);
    chk("c3_rdata", bus.rsp_rdata_o, 0);
    chk("c3_psel", bus.psel_o, 0);
    step();
    chk("idle_rspv", bus.rsp_valid_o, 0);
    chk("idle_cmdrdy", bus.cmd_ready_o, 1);
    chk("idle_paddr", bus.paddr_o, 3);

    // read back
    xfer(0, 4'h3, 8'h00, rd, e, lat, acc, stable);
    chk("rd3_data", rd, 8'hA5);
    chk("rd3_err", e, 0);
    chk("rd3_lat", lat, 3);
    step();

    // 3 wait states
    waits = 3;
    xfer(1, 4'h7, 8'h3C, rd, e, lat, acc, stable);
    chk("ws_acc", acc, 4);
    chk("ws_stable", stable, 1);
    chk("ws_lat", lat, 6);
    step();
    chk("ws_single", bus.rsp_valid_o, 0);
    xfer(0, 4'h7, 8'h00, rd, e, lat, acc, stable);
    chk("ws_rd", rd, 8'h3C);
    step();
    waits = 0;

    // consumer stalls the response for 5 cycles
    bus.rsp_ready_i = 0;
    xfer(0, 4'h3, 8'h00, rd, e, lat, acc, stable);
    bus.cmd_valid_i = 1; bus.cmd_write_i = 1;
    bus.cmd_addr_i = 4'h9; bus.cmd_wdata_i = 8'h5A;
    for (int i = 0; i < 5; i++) begin
      chk("bp_rspv", bus.rsp_valid_o, 1);
      chk("bp_rdata", bus.rsp_rdata_o, 8'hA5);
      chk("bp_cmdrdy", bus.cmd_ready_o, 0);
      chk("bp_psel", bus.psel_o, 0);
      step();
    end
    bus.rsp_ready_i = 1;
    step();
    bus.cmd_valid_i = 0;
    chk("bp_done", bus.rsp_valid_o, 0);
    chk("bp_noacc", bus.psel_o, 0);
    xfer(1, 4'h9, 8'h5A, rd, e, lat, acc, stable);
    chk("bp_new_lat", lat, 3);
    step();

    // slave error on read keeps captured data
    err_flag = 1;
    xfer(0, 4'h9, 8'h00, rd, e, lat, acc, stable);
    chk("se_err", e, 1);
    chk("se_rd", rd, 8'h5A);
    step();
    err_flag = 0;

    // reset during ACCESS
    waits = 10;
    bus.cmd_valid_i = 1; bus.cmd_write_i = 1;
    bus.cmd_addr_i = 4'h5; bus.cmd_wdata_i = 8'h77;
    step();
    bus.cmd_valid_i = 0;
    step();
    step();
    chk("ra_in_acc", bus.penable_o, 1);
    rst_n = 0;
    #1;
    chk("ra_psel", bus.psel_o, 0);
    chk("ra_pen", bus.penable_o, 0);
    chk("ra_rspv", bus.rsp_valid_o, 0);
    chk("ra_paddr", bus.paddr_o, 0);
    chk("ra_cmdrdy", bus.cmd_ready_o, 0);
    step();
    rst_n = 1;
    waits = 0;
    step();
    chk("ra_norsp", bus.rsp_valid_o, 0);
    chk("ra_mem5", mem[5], 0);
    xfer(1, 4'h5, 8'h66, rd, e, lat, acc, stable);
    chk("ra_wr_err", e, 0);
    step();
    xfer(0, 4'h5, 8'h00, rd, e, lat, acc, stable);
    chk("ra_rd", rd, 8'h66);
    step();

    // address boundaries
    xfer(1, 4'hF, 8'hFF, rd, e, lat, acc, stable);
    step();
    xfer(1, 4'h0, 8'h11, rd, e, lat, acc, stable);
    step();
    xfer(0, 4'hF, 8'h00, rd, e, lat, acc, stable);
    chk("a15_rd", rd, 8'hFF);
    step();
    xfer(0, 4'h0, 8'h00, rd, e, lat, acc, stable);
    chk("a0_rd", rd, 8'h11);
    step();

`ifdef APB_TIMEOUT_EN
    stuck = 1;
    xfer(0, 4'hF, 8'h00, rd, e, lat, acc, stable);
    chk("to_acc", acc, TIMEOUT_CYCLES);
    chk("to_err", e, 1);
    chk("to_rd", rd, 0);
    chk("to_psel", bus.psel_o, 0);
    stuck = 0;
    step();
    chk("to_idle", bus.cmd_ready_o, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- Single-outstanding APB master that sits directly upstream of the 16x8 APB slave memory and drives its psel/penable/pwrite/paddr/pwdata pins.
- Accepts read/write commands on a valid/ready command port and sequences the APB SETUP and ACCESS phases.
- Returns read data and the error status on a valid/ready response port.
- Gives test environments and on-chip initiators a simple request/response front end to the slave.

Parameters:
- WIDTH, 8, data width of pwdata/prdata and the command/response data fields.
- MEM_DEPTH, 16, slave memory depth in words.
- ADDR_WIDTH, $clog2(MEM_DEPTH) = 4, address width.
- TIMEOUT_CYCLES, 16, maximum number of ACCESS cycles with pready low before abort. Used only with APB_TIMEOUT_EN.

Ports:
- pclk_i  in  1  clock; all flops sample on the rising edge.
- presetn_i  in  1  asynchronous active-low reset.
- cmd_valid_i  in  1  command present.
- cmd_ready_o  out  1  bridge can accept a command.
- cmd_write_i  in  1  1 = write, 0 = read.
- cmd_addr_i  in  ADDR_WIDTH  target address.
- cmd_wdata_i  in  WIDTH  write data.
- rsp_valid_o  out  1  response available.
- rsp_ready_i  in  1  consumer takes the response.
- rsp_rdata_o  out  WIDTH  read data; 0 for writes.
- rsp_err_o  out  1  slave error, or timeout when enabled.
- psel_o  out  1  APB select.
- penable_o  out  1  APB enable.
- pwrite_o  out  1  APB direction.
- paddr_o  out  ADDR_WIDTH  APB address.
- pwdata_o  out  WIDTH  APB write data.
- prdata_i  in  WIDTH  APB read data.
- pready_i  in  1  APB ready.
- pslverr_i  in  1  APB slave error.

Behaviour:
- Reset (presetn_i low, asynchronous): state IDLE. All outputs 0, except cmd_ready_o, which is 1 once reset is released. Any in-flight transfer is dropped and produces no response.
- FSM states: IDLE, SETUP, ACCESS, RESP. All APB outputs are registered.
- IDLE:
  - cmd_ready_o = 1.
  - On cmd_valid_i & cmd_ready_o, latch write/addr/wdata, go to SETUP.
- SETUP (exactly 1 cycle):
  - psel_o = 1, penable_o = 0; paddr_o/pwrite_o/pwdata_o hold the latched values.
  - Go to ACCESS.
- ACCESS:
  - psel_o = 1, penable_o = 1; address and data stay stable.
  - When pready_i = 1 at an edge: capture pslverr_i, and prdata_i for reads only (rdata = 0 for writes). Drop psel_o/penable_o to 0 and go to RESP.
  - pready_i low: remain in ACCESS indefinitely (unless the timeout feature is enabled).
- RESP:
  - rsp_valid_o = 1; rsp_rdata_o and rsp_err_o hold steady until rsp_ready_i.
  - On rsp_valid_o & rsp_ready_i, go to IDLE.
  - rsp_ready_i may already be high on entry; the handshake then completes in one cycle.
- Minimum latency (zero-wait slave): command accepted at edge 0; SETUP in cycle 1; ACCESS in cycle 2; rsp_valid_o high in cycle 3.
- Throughput: at most one command per 4 cycles. cmd_ready_o is 0 in SETUP, ACCESS and RESP; commands presented then are not accepted.
- paddr_o/pwdata_o/pwrite_o keep their last value when idle. psel_o = 0 outside SETUP and ACCESS.
- Out-of-range addresses cannot occur (ADDR_WIDTH covers MEM_DEPTH). pslverr_i is passed through unmodified.
- pslverr_i = 1 on a read: rsp_rdata_o still carries the captured prdata_i; rsp_err_o = 1.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- Defined:
  - A wait counter starts at 0 on entry to ACCESS and increments each ACCESS cycle with pready_i = 0.
  - When the count reaches TIMEOUT_CYCLES, the bridge drops psel_o/penable_o, goes to RESP with rsp_err_o = 1 and rsp_rdata_o = 0.
  - A later pready_i is ignored.
- Undefined: no counter exists; ACCESS waits forever for pready_i. TIMEOUT_CYCLES is unused.

Decomposition:
- Package apb_pkg holds:
  - WIDTH, MEM_DEPTH, ADDR_WIDTH constants.
  - Enum apb_mst_state_e {IDLE, SETUP, ACCESS, RESP}.
  - Struct apb_cmd_t {write, addr, wdata}.
- Sub-module apb_wait_counter: saturating counter with clear, enable and a terminal-count output. It is instantiated only under APB_TIMEOUT_EN.

Test Plan:
- Write addr 4'h3, data 8'hA5, zero-wait slave -> psel_o high in cycle 1, penable_o high in cycle 2, paddr_o = 3, pwdata_o = A5; rsp_valid_o in cycle 3 with rsp_err_o = 0, rsp_rdata_o = 0.
- Read addr 3 after the previous write -> rsp_rdata_o = 8'hA5, rsp_err_o = 0.
- Slave holds pready_i low for 3 cycles -> ACCESS lasts 4 cycles; paddr_o/pwdata_o stable throughout; one response only.
- rsp_ready_i held low for 5 cycles -> rsp_valid_o and data held; cmd_ready_o stays 0; a new command is accepted only after the handshake.
- presetn_i asserted during ACCESS -> all outputs 0 immediately; no response issued; the next command after release completes normally.
- APB_TIMEOUT_EN defined, TIMEOUT_CYCLES = 16, pready_i stuck low -> abort after 16 wait cycles, rsp_err_o = 1, rsp_rdata_o = 0, psel_o = 0.
